// File: rtl/decode_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage: parameter defaults, RV64
// major-opcode constants, the immediate-format enum and the opcode
// classification helper used by the stage.
package decode_issue_stage_pkg;

  localparam int DEFAULT_XLEN               = 64;
  localparam int DEFAULT_INSTRUCTION_LENGTH = 32;
  localparam int DEFAULT_NUM_REGS           = 32;
  localparam int DEFAULT_REGISTER_SIZE      = $clog2(DEFAULT_NUM_REGS);
  localparam int DEFAULT_STALL_CNT_W        = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // IMM_R doubles as "no immediate" (R-type and unknown opcodes)
  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    imm_fmt_e fmt;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     writes_rd;
  } op_info_t;

  function automatic op_info_t decode_opcode(input logic [6:0] opc);
    op_info_t info;
    info.fmt       = IMM_R;
    info.uses_rs1  = 1'b0;
    info.uses_rs2  = 1'b0;
    info.writes_rd = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_32: begin
        info.uses_rs1 = 1'b1; info.uses_rs2 = 1'b1; info.writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
        info.fmt = IMM_I; info.uses_rs1 = 1'b1; info.writes_rd = 1'b1;
      end
      OPC_STORE: begin
        info.fmt = IMM_S; info.uses_rs1 = 1'b1; info.uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        info.fmt = IMM_B; info.uses_rs1 = 1'b1; info.uses_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        info.fmt = IMM_U; info.writes_rd = 1'b1;
      end
      OPC_JAL: begin
        info.fmt = IMM_J; info.writes_rd = 1'b1;
      end
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/decode_issue_stage_regfile.sv
// Architectural register file: NUM_REGS x XLEN, two asynchronous read ports,
// one synchronous write port. Register 0 always reads zero and ignores
// writes. Contents are not reset.
//   clk                 - write clock
//   rs1_addr / rs1_data - read port 1
//   rs2_addr / rs2_data - read port 2
//   we / waddr / wdata  - write port
module decode_issue_stage_regfile
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN          = DEFAULT_XLEN,
  parameter int NUM_REGS      = DEFAULT_NUM_REGS,
  parameter int REGISTER_SIZE = DEFAULT_REGISTER_SIZE
) (
  input  logic                     clk,
  input  logic [REGISTER_SIZE-1:0] rs1_addr,
  output logic [XLEN-1:0]          rs1_data,
  input  logic [REGISTER_SIZE-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     we,
  input  logic [REGISTER_SIZE-1:0] waddr,
  input  logic [XLEN-1:0]          wdata
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes the fetched instruction, reads operands (with
// writeback forwarding), checks a per-register busy scoreboard plus the
// in-flight output slot for hazards, and presents a one-entry registered
// issue slot to execute.
//   clk, rst                   - clock, synchronous active-high reset
//   in_valid/in_ready          - fetch handshake; in_instr, in_pc
//   out_valid/out_ready        - execute handshake; out_instr, out_pc,
//                                out_rs1_data, out_rs2_data, out_imm,
//                                out_rd, out_rd_we
//   wb_enable/wb_addr/wb_data  - writeback: writes file, clears busy bit
//   flush                      - kills the output slot
//   stall_cycles               - saturating count of hazard stall cycles
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN               = DEFAULT_XLEN,
  parameter int INSTRUCTION_LENGTH = DEFAULT_INSTRUCTION_LENGTH,
  parameter int NUM_REGS           = DEFAULT_NUM_REGS,
  parameter int STALL_CNT_W        = DEFAULT_STALL_CNT_W,
  localparam int REGISTER_SIZE     = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] in_instr,
  input  logic [XLEN-1:0]               in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTRUCTION_LENGTH-1:0] out_instr,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_rs1_data,
  output logic [XLEN-1:0]               out_rs2_data,
  output logic [XLEN-1:0]               out_imm,
  output logic [REGISTER_SIZE-1:0]      out_rd,
  output logic                          out_rd_we,
  input  logic                          wb_enable,
  input  logic [REGISTER_SIZE-1:0]      wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          flush,
  output logic [STALL_CNT_W-1:0]        stall_cycles
);

  op_info_t                 info;
  logic [REGISTER_SIZE-1:0] rs1, rs2, rd;
  logic                     rd_we;
  logic [XLEN-1:0]          imm;
  logic [XLEN-1:0]          rf_rs1, rf_rs2, rs1_val, rs2_val;
  logic                     wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic                     slot_we;
  logic                     rs1_haz, rs2_haz, rd_haz, hazard;
  logic                     accept, out_fire;
  logic [NUM_REGS-1:0]      busy, busy_next;

  logic signed [11:0] imm_i, imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign info  = decode_opcode(in_instr[6:0]);
  assign rd    = in_instr[7 +: REGISTER_SIZE];
  assign rs1   = in_instr[15 +: REGISTER_SIZE];
  assign rs2   = in_instr[20 +: REGISTER_SIZE];
  assign rd_we = info.writes_rd && (rd != '0);

  always_comb begin
    imm_i = in_instr[31:20];
    imm_s = {in_instr[31:25], in_instr[11:7]};
    imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    case (info.fmt)
      IMM_I:   imm = XLEN'(imm_i);
      IMM_S:   imm = XLEN'(imm_s);
      IMM_B:   imm = XLEN'(imm_b);
      IMM_U:   imm = XLEN'(imm_u);
      IMM_J:   imm = XLEN'(imm_j);
      default: imm = '0;
    endcase
  end

  decode_issue_stage_regfile #(
    .XLEN          (XLEN),
    .NUM_REGS      (NUM_REGS),
    .REGISTER_SIZE (REGISTER_SIZE)
  ) regFile (
    .clk      (clk),
    .rs1_addr (rs1),
    .rs1_data (rf_rs1),
    .rs2_addr (rs2),
    .rs2_data (rf_rs2),
    .we       (wb_enable),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  assign wb_hit_rs1 = wb_enable && (wb_addr == rs1);
  assign wb_hit_rs2 = wb_enable && (wb_addr == rs2);
  assign wb_hit_rd  = wb_enable && (wb_addr == rd);

  // The file read does not see this cycle's write, so forward it here
  assign rs1_val = (wb_hit_rs1 && (rs1 != '0)) ? wb_data : rf_rs1;
  assign rs2_val = (wb_hit_rs2 && (rs2 != '0)) ? wb_data : rf_rs2;

  // The slot's destination is not in the scoreboard until it hands off, and
  // a concurrent writeback is always older than it, so no bypass applies.
  assign slot_we = out_valid && out_rd_we;
  assign rs1_haz = info.uses_rs1 &&
                   ((busy[rs1] && !wb_hit_rs1) || (slot_we && (out_rd == rs1)));
  assign rs2_haz = info.uses_rs2 &&
                   ((busy[rs2] && !wb_hit_rs2) || (slot_we && (out_rd == rs2)));
  assign rd_haz  = rd_we &&
                   ((busy[rd] && !wb_hit_rd) || (slot_we && (out_rd == rd)));
  assign hazard  = in_valid && (rs1_haz || rs2_haz || rd_haz);

  assign in_ready = !rst && !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_instr    <= in_instr;
        out_pc       <= in_pc;
        out_rs1_data <= info.uses_rs1 ? rs1_val : '0;
        out_rs2_data <= info.uses_rs2 ? rs2_val : '0;
        out_imm      <= imm;
        out_rd       <= rd_we ? rd : '0;
        out_rd_we    <= rd_we;
      end
    end
  end

  // Set is applied after clear so a same-cycle issue of the register wins
  always_comb begin
    busy_next = busy;
    if (wb_enable) begin
      busy_next[wb_addr] = 1'b0;
    end
    if (out_fire && out_rd_we) begin
      busy_next[out_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hazard && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: expected slot contents are queued
// when an instruction is offered for issue and compared when the slot is
// observed at the execute interface.
module tb_decode_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_rs1_data;
  logic [63:0] out_rs2_data;
  logic [63:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        flush;
  logic [31:0] stall_cycles;

  decode_issue_stage #(
    .XLEN               (64),
    .INSTRUCTION_LENGTH (32),
    .NUM_REGS           (32),
    .STALL_CNT_W        (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we),
    .wb_enable    (wb_enable),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .stall_cycles (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } exp_t;

  exp_t sb[$];
  exp_t g[5];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_in(input logic [31:0] instr, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic push(input logic [31:0] instr, input logic [63:0] pc, input logic [63:0] imm,
                      input logic [4:0] rd, input logic we, input logic [63:0] a,
                      input logic [63:0] b);
    exp_t e;
    e.instr = instr; e.pc = pc; e.imm = imm; e.rd = rd; e.we = we; e.rs1 = a; e.rs2 = b;
    sb.push_back(e);
  endtask

  task automatic check_slot(input string tag, input bit pop);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb[0];
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_instr"}, 64'(out_instr), 64'(e.instr));
      chk({tag, "_pc"},    out_pc,         e.pc);
      chk({tag, "_imm"},   out_imm,        e.imm);
      chk({tag, "_rd"},    64'(out_rd),    64'(e.rd));
      chk({tag, "_rd_we"}, 64'(out_rd_we), 64'(e.we));
      chk({tag, "_rs1"},   out_rs1_data,   e.rs1);
      chk({tag, "_rs2"},   out_rs2_data,   e.rs2);
      if (pop) void'(sb.pop_front());
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_instr"},     64'(out_instr), 64'd0);
    chk({tag, "_pc"},        out_pc,         64'd0);
    chk({tag, "_imm"},       out_imm,        64'd0);
    chk({tag, "_rs1"},       out_rs1_data,   64'd0);
    chk({tag, "_rs2"},       out_rs2_data,   64'd0);
    chk({tag, "_rd"},        64'(out_rd),    64'd0);
    chk({tag, "_rd_we"},     64'(out_rd_we), 64'd0);
    chk({tag, "_stall"},     64'(stall_cycles), 64'd0);
    chk({tag, "_busy"},      64'(dut.busy),  64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    wb_enable = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    check_reset_state("rst");
    rst = 1'b0;

    // addi x5,x0,7 issues, slot valid next cycle, busy[5] set on hand-off
    drive_in(enc_i(12'd7, 5'd0, 5'd5, 7'b0010011), 64'h100);
    out_ready = 1'b1;
    #1 chk("addi_in_ready", 64'(in_ready), 64'd1);
    push(in_instr, 64'h100, 64'd7, 5'd5, 1'b1, 64'd0, 64'd0);
    cyc();
    in_valid = 1'b0;
    check_slot("addi", 1'b1);
    chk("addi_busy5_pre", 64'(dut.busy[5]), 64'd0);
    cyc();
    chk("addi_drained", 64'(out_valid), 64'd0);
    chk("addi_busy5", 64'(dut.busy[5]), 64'd1);

    // add x6,x5,x5 stalls three cycles, then issues on the x5 writeback
    drive_in(enc_r(5'd5, 5'd5, 5'd6), 64'h104);
    #1 chk("raw_in_ready", 64'(in_ready), 64'd0);
    repeat (3) cyc();
    chk("raw_stall3", 64'(stall_cycles), 64'd3);
    chk("raw_in_ready3", 64'(in_ready), 64'd0);
    wb_enable = 1'b1; wb_addr = 5'd5; wb_data = 64'd7;
    out_ready = 1'b0;
    #1 chk("fwd_in_ready", 64'(in_ready), 64'd1);
    push(in_instr, 64'h104, 64'd0, 5'd6, 1'b1, 64'd7, 64'd7);
    cyc();
    wb_enable = 1'b0;
    chk("fwd_stall", 64'(stall_cycles), 64'd3);

    // Back-pressure for four cycles with an independent instruction waiting
    drive_in(enc_i(12'hFFF, 5'd0, 5'd7, 7'b0010011), 64'h108);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_slot("hold", 1'b0);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_busy6", 64'(dut.busy[6]), 64'd0);
      cyc();
    end
    chk("hold_stall", 64'(stall_cycles), 64'd3);
    out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    check_slot("release", 1'b1);
    push(in_instr, 64'h108, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b1, 64'd0, 64'd0);
    cyc();
    chk("release_busy6", 64'(dut.busy[6]), 64'd1);

    // Flush with a same-cycle hand-off: slot dies, busy[7] stays clear
    flush = 1'b1;
    drive_in(enc_r(5'd0, 5'd6, 5'd8), 64'h10c);
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    check_slot("flush", 1'b1);
    cyc();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_busy7", 64'(dut.busy[7]), 64'd0);
    chk("flush_stall", 64'(stall_cycles), 64'd3);
    flush = 1'b0;

    // Writeback clear and issue-set of x5 on the same edge: set wins
    wb_enable = 1'b1; wb_addr = 5'd6; wb_data = 64'h55;
    drive_in(enc_i(12'd3, 5'd0, 5'd5, 7'b0010011), 64'h110);
    #1 chk("waw_in_ready", 64'(in_ready), 64'd1);
    push(in_instr, 64'h110, 64'd3, 5'd5, 1'b1, 64'd0, 64'd0);
    cyc();
    in_valid = 1'b0;
    wb_enable = 1'b1; wb_addr = 5'd5; wb_data = 64'h33;
    check_slot("waw", 1'b1);
    cyc();
    wb_enable = 1'b0;
    chk("set_wins_busy5", 64'(dut.busy[5]), 64'd1);
    chk("wb_busy6", 64'(dut.busy[6]), 64'd0);

    // Back-to-back immediate formats (x6 = 0x55)
    g[0] = '{instr: enc_s(12'hFFC, 5'd6, 5'd6), pc: 64'h200, imm: 64'hFFFF_FFFF_FFFF_FFFC,
             rd: 5'd0, we: 1'b0, rs1: 64'h55, rs2: 64'h55};
    g[1] = '{instr: enc_b(13'h1FF8, 5'd0, 5'd6), pc: 64'h204, imm: 64'hFFFF_FFFF_FFFF_FFF8,
             rd: 5'd0, we: 1'b0, rs1: 64'h55, rs2: 64'd0};
    g[2] = '{instr: enc_u(20'h80000, 5'd9), pc: 64'h208, imm: 64'hFFFF_FFFF_8000_0000,
             rd: 5'd9, we: 1'b1, rs1: 64'd0, rs2: 64'd0};
    g[3] = '{instr: enc_j(21'h800, 5'd1), pc: 64'h20c, imm: 64'h800,
             rd: 5'd1, we: 1'b1, rs1: 64'd0, rs2: 64'd0};
    g[4] = '{instr: enc_j(21'h0, 5'd0), pc: 64'h210, imm: 64'd0,
             rd: 5'd0, we: 1'b0, rs1: 64'd0, rs2: 64'd0};
    for (int k = 0; k < 5; k++) begin
      drive_in(g[k].instr, g[k].pc);
      #1 chk("fmt_in_ready", 64'(in_ready), 64'd1);
      if (k > 0) check_slot("fmt", 1'b1);
      sb.push_back(g[k]);
      cyc();
    end
    in_valid = 1'b0;
    check_slot("fmt", 1'b1);
    cyc();
    chk("fmt_drained", 64'(out_valid), 64'd0);

    // Source matches the valid slot's destination before it reaches busy
    drive_in(enc_i(12'd1, 5'd0, 5'd10, 7'b0010011), 64'h300);
    #1 chk("slot_in_ready", 64'(in_ready), 64'd1);
    push(in_instr, 64'h300, 64'd1, 5'd10, 1'b1, 64'd0, 64'd0);
    cyc();
    drive_in(enc_r(5'd0, 5'd10, 5'd11), 64'h304);
    #1 chk("slot_rd_hazard", 64'(in_ready), 64'd0);
    check_slot("slot", 1'b1);
    cyc();
    chk("slot_stall", 64'(stall_cycles), 64'd4);
    chk("slot_busy10", 64'(dut.busy[10]), 64'd1);
    chk("busy10_in_ready", 64'(in_ready), 64'd0);
    cyc();
    chk("busy10_stall", 64'(stall_cycles), 64'd5);
    wb_enable = 1'b1; wb_addr = 5'd10; wb_data = 64'h77;
    #1 chk("wb10_in_ready", 64'(in_ready), 64'd1);
    push(in_instr, 64'h304, 64'd0, 5'd11, 1'b1, 64'h77, 64'd0);
    cyc();
    wb_enable = 1'b0; in_valid = 1'b0;
    check_slot("wb10", 1'b1);
    chk("wb10_stall", 64'(stall_cycles), 64'd5);
    cyc();

    // Reset in the middle of a stall on x11
    drive_in(enc_r(5'd0, 5'd11, 5'd12), 64'h308);
    #1 chk("mid_in_ready", 64'(in_ready), 64'd0);
    repeat (2) cyc();
    chk("mid_stall", 64'(stall_cycles), 64'd7);
    rst = 1'b1;
    #1 chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    cyc();
    sb.delete();
    check_reset_state("mid_rst");
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
